tank_sprite_scheduler: RTL and testbench

//  Per-scanline sprite fetch scheduler for the shared 16x16 tank sprite ROM
//  (128 rows x 16 cols, 4-bit palette index, 8 frames = {dir[1:0],anim}).
//  On each line_start, snapshots all tank slots, fetches the matching ROM row
//  per visible tank and writes opaque pixels into the next-line buffer.

---
 rtl/tank_sprite_scheduler.sv | 168 ++++++++++++++++
 tb/tb_tank_sprite_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tank_sprite_scheduler.sv
// Per-scanline sprite fetch scheduler for the shared 16x16 tank sprite ROM.
// On line_start, all tank slots are snapshotted. Slots are then walked from
// NUM_TANKS-1 down to 0. For each tank visible on the line, one ROM row is
// fetched and its opaque pixels are written into the next-line buffer.

// Per-slot vertical hit test against the snapshotted scanline.
module tank_sprite_slot #(
    parameter int Y_W = 10
) (
    input  logic [Y_W-1:0] line_y,
    input  logic           vld,
    input  logic [Y_W-1:0] top_y,
    output logic           hit,
    output logic [3:0]     row
);
    logic [Y_W-1:0] dy;

    // Unsigned, non-wrapping test: the line must be at or below the top edge
    // and within the 16-row sprite height.
    always_comb begin
        dy  = line_y - top_y;
        hit = vld && (line_y >= top_y) && (dy < Y_W'(16));
        row = dy[3:0];
    end
endmodule

module tank_sprite_scheduler #(
    parameter int NUM_TANKS = 4,
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int LINE_W    = 640
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     line_start,
    input  logic [Y_W-1:0]           next_y,
    input  logic [NUM_TANKS-1:0]     tank_valid,
    input  logic [NUM_TANKS*X_W-1:0] tank_x,
    input  logic [NUM_TANKS*Y_W-1:0] tank_y,
    input  logic [NUM_TANKS*2-1:0]   tank_dir,
    input  logic [NUM_TANKS-1:0]     tank_anim,
    output logic [6:0]               rom_row,
    output logic [3:0]               rom_col,
    input  logic [3:0]               rom_data,
    output logic                     lb_we,
    output logic [X_W-1:0]           lb_addr,
    output logic [3:0]               lb_data,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);
    localparam int SW = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1;
    localparam logic [X_W:0] LINE_LIM = (X_W+1)'(LINE_W);

    typedef enum logic [2:0] {S_IDLE, S_EVAL, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t state, nxt;

    // Snapshot of the slot registers taken when a fill is accepted.
    logic [Y_W-1:0]                snap_ny;
    logic [NUM_TANKS-1:0]          snap_vld;
    logic [NUM_TANKS-1:0][X_W-1:0] snap_x;
    logic [NUM_TANKS-1:0][Y_W-1:0] snap_y;
    logic [NUM_TANKS-1:0][1:0]     snap_dir;
    logic [NUM_TANKS-1:0]          snap_anim;

    logic [NUM_TANKS-1:0]          hit_v;
    logic [NUM_TANKS-1:0][3:0]     row_v;

    logic [SW-1:0]                 cur;
    logic                          cur_hit;
    logic                          accept;
    logic                          wr_vld;    // rom_data this cycle belongs to a fetched column
    logic [3:0]                    wcol;      // column whose data is arriving now
    logic [X_W:0]                  wsum;

    assign accept  = (state == S_IDLE) && line_start;
    assign cur_hit = hit_v[cur];

    // One hit-test lane per slot, all evaluated on the frozen snapshot.
    for (genvar i = 0; i < NUM_TANKS; i++) begin : g_slot
        tank_sprite_slot #(.Y_W(Y_W)) u_slot (
            .line_y (snap_ny),
            .vld    (snap_vld[i]),
            .top_y  (snap_y[i]),
            .hit    (hit_v[i]),
            .row    (row_v[i])
        );
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= nxt;
    end

    // Next state. Slot 0 is visited last, so it wins any overlap.
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  if (line_start) nxt = S_EVAL;
            S_EVAL:  if (cur_hit)          nxt = S_FETCH;
                     else if (cur == '0)   nxt = S_DONE;
                     else                  nxt = S_EVAL;
            S_FETCH: if (rom_col == 4'd15) nxt = S_DRAIN;
            S_DRAIN: nxt = (cur == '0) ? S_DONE : S_EVAL;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Capture all slots on an accepted line_start; later slot changes are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_ny   <= '0;
            snap_vld  <= '0;
            snap_x    <= '0;
            snap_y    <= '0;
            snap_dir  <= '0;
            snap_anim <= '0;
        end else if (accept) begin
            snap_ny   <= next_y;
            snap_vld  <= tank_valid;
            snap_x    <= tank_x;
            snap_y    <= tank_y;
            snap_dir  <= tank_dir;
            snap_anim <= tank_anim;
        end
    end

    // Slot cursor, ROM address generation, write-pipe tracking and overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur      <= '0;
            rom_row  <= '0;
            rom_col  <= '0;
            wr_vld   <= 1'b0;
            wcol     <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= line_start && (state != S_IDLE);
            wr_vld   <= (state == S_FETCH);
            wcol     <= rom_col;
            if (accept) begin
                cur <= SW'(NUM_TANKS - 1);
            end else if (((state == S_EVAL && !cur_hit) || state == S_DRAIN) && cur != '0) begin
                cur <= cur - 1'b1;
            end
            if (state == S_EVAL && cur_hit) begin
                rom_row <= {snap_dir[cur], snap_anim[cur], row_v[cur]};
                rom_col <= 4'd0;
            end else if (state == S_FETCH && rom_col != 4'd15) begin
                rom_col <= rom_col + 4'd1;
            end
        end
    end

    // Pixel arrives one cycle after its column; zero is transparent and any
    // column past the right edge of the visible line is dropped.
    always_comb begin
        wsum    = {1'b0, snap_x[cur]} + {{(X_W-3){1'b0}}, wcol};
        lb_we   = wr_vld && (rom_data != 4'd0) && (wsum < LINE_LIM);
        lb_addr = lb_we ? wsum[X_W-1:0] : '0;
        lb_data = lb_we ? rom_data : 4'd0;
        busy    = (state == S_EVAL) || (state == S_FETCH) || (state == S_DRAIN);
        done    = (state == S_DONE);
    end
endmodule

// File: tb/tb_tank_sprite_scheduler.sv
// Scoreboard bench: a line-level reference model pushes the expected pixel
// writes, done cycle and overflow cycles. A negedge monitor checks the DUT
// outputs against those expectations.
module tb_tank_sprite_scheduler;
    localparam int NT = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          line_start = 1'b0;
    logic [9:0]    next_y = '0;
    logic [NT-1:0] tank_valid = '0;
    logic [NT*10-1:0] tank_x = '0;
    logic [NT*10-1:0] tank_y = '0;
    logic [NT*2-1:0]  tank_dir = '0;
    logic [NT-1:0] tank_anim = '0;
    logic [6:0]    rom_row;
    logic [3:0]    rom_col;
    logic [3:0]    rom_data = '0;
    logic          lb_we;
    logic [9:0]    lb_addr;
    logic [3:0]    lb_data;
    logic          busy, done, overflow;

    tank_sprite_scheduler #(.NUM_TANKS(NT), .X_W(10), .Y_W(10), .LINE_W(640)) dut (
        .clk(clk), .reset_n(reset_n), .line_start(line_start), .next_y(next_y),
        .tank_valid(tank_valid), .tank_x(tank_x), .tank_y(tank_y),
        .tank_dir(tank_dir), .tank_anim(tank_anim),
        .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data),
        .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sprite ROM: data one cycle after address.
    int rom [128][16];
    always @(posedge clk) rom_data <= 4'(rom[rom_row][rom_col]);

    int checks = 0, errors = 0;
    int exp_addr[$], exp_data[$], exp_done[$], exp_ovf[$];
    int tv[NT], tx[NT], ty[NT], td[NT], ta[NT];
    int last_done;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply_tanks();
        for (int s = 0; s < NT; s++) begin
            tank_valid[s]       = tv[s][0];
            tank_x[s*10 +: 10]  = tx[s][9:0];
            tank_y[s*10 +: 10]  = ty[s][9:0];
            tank_dir[s*2 +: 2]  = td[s][1:0];
            tank_anim[s]        = ta[s][0];
        end
    endtask

    // Reference model: one line fill from the slot values at acceptance.
    task automatic model(input int ny, input int e);
        int h, r, d;
        h = 0;
        for (int s = NT-1; s >= 0; s--) begin
            if (tv[s] != 0 && ny >= ty[s] && ny - ty[s] < 16) begin
                h++;
                r = td[s]*32 + ta[s]*16 + (ny - ty[s]);
                for (int c = 0; c < 16; c++) begin
                    d = rom[r][c];
                    if (d != 0 && tx[s] + c < 640) begin
                        exp_addr.push_back(tx[s] + c);
                        exp_data.push_back(d);
                    end
                end
            end
        end
        // Cycle 1 is the negedge right after the sampling edge; done lands at cycle NT+17h+1.
        last_done = e + NT + 17*h;
        exp_done.push_back(last_done);
    endtask

    task automatic start_line(input int ny);
        @(negedge clk);
        apply_tanks();
        next_y = 10'(ny);
        line_start = 1'b1;
        @(posedge clk);
        #1;
        line_start = 1'b0;
        model(ny, cyc);
    endtask

    // A line_start that must be rejected as overflow; the inputs are scrambled.
    task automatic poke_overflow();
        next_y = 10'($urandom_range(0, 479));
        tank_valid = 4'($urandom);
        tank_x = 40'({$urandom, $urandom});
        line_start = 1'b1;
        @(posedge clk);
        #1;
        line_start = 1'b0;
        exp_ovf.push_back(cyc);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && exp_done.size() > 0; i++) @(negedge clk);
        if (exp_done.size() > 0) begin
            chk("fill_timeout", 0, 1);
            exp_done.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rom_row"}, rom_row, 0);
        chk({tag, "_rom_col"}, rom_col, 0);
        chk({tag, "_lb_we"}, lb_we, 0);
        chk({tag, "_lb_addr"}, lb_addr, 0);
        chk({tag, "_lb_data"}, lb_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    task automatic one_tank(input int x, input int y, input int dir, input int anim);
        for (int s = 0; s < NT; s++) begin tv[s] = 0; tx[s] = 0; ty[s] = 0; td[s] = 0; ta[s] = 0; end
        tv[0] = 1; tx[0] = x; ty[0] = y; td[0] = dir; ta[0] = anim;
    endtask

    // Monitor: compare each observable event against the scoreboard queues.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("busy", busy, (exp_done.size() > 0 && cyc < exp_done[0]) ? 1 : 0);
            if (lb_we) begin
                if (exp_addr.size() == 0) chk("lb_we_unexpected", 1, 0);
                else begin
                    chk("lb_addr", lb_addr, exp_addr.pop_front());
                    chk("lb_data", lb_data, exp_data.pop_front());
                end
            end
            if (done) begin
                if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    chk("done_cycle", cyc, exp_done.pop_front());
                    chk("writes_left_at_done", exp_addr.size(), 0);
                    exp_addr.delete();
                    exp_data.delete();
                end
            end else if (exp_done.size() > 0 && cyc >= exp_done[0]) begin
                chk("done_missing", 0, 1);
                void'(exp_done.pop_front());
            end
            if (overflow) begin
                if (exp_ovf.size() == 0) chk("overflow_unexpected", 1, 0);
                else chk("overflow_cycle", cyc, exp_ovf.pop_front());
            end else if (exp_ovf.size() > 0 && cyc >= exp_ovf[0]) begin
                chk("overflow_missing", 0, 1);
                void'(exp_ovf.pop_front());
            end
        end
    end

    initial begin
        int ny, k;
        for (int r = 0; r < 128; r++)
            for (int c = 0; c < 16; c++)
                rom[r][c] = ($urandom_range(0, 9) < 4) ? 0 : $urandom_range(1, 15);
        for (int c = 0; c < 16; c++) rom[1][c] = (c >= 4 && c <= 14) ? c : 0;
        for (int c = 0; c < 16; c++) rom[83][c] = c + 1;

        // Reset state
        #2;
        check_idle_outputs("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // 1: single visible tank, writes 104..114
        one_tank(100, 50, 0, 0);
        start_line(51);
        wait_done();
        // 2: line just below and just above the sprite
        start_line(66);
        wait_done();
        start_line(49);
        wait_done();
        // 3: two overlapping tanks, slot 1 first then slot 0
        one_tank(200, 10, 1, 1);
        tv[1] = 1; tx[1] = 200; ty[1] = 10; td[1] = 3; ta[1] = 0;
        start_line(12);
        wait_done();
        // 4: right-edge clipping, rom_row 83
        one_tank(630, 40, 2, 1);
        start_line(43);
        wait_done();
        // 5: line_start during fill (cycle 5) and during the done cycle
        one_tank(300, 100, 1, 0);
        start_line(105);
        repeat (5) @(negedge clk);
        poke_overflow();
        while (cyc < last_done) @(negedge clk);
        poke_overflow();
        wait_done();
        // 6: reset mid-FETCH, then a clean fill
        one_tank(100, 50, 0, 0);
        start_line(51);
        repeat (10) @(negedge clk);
        #2;
        reset_n = 1'b0;
        exp_addr.delete(); exp_data.delete(); exp_done.delete(); exp_ovf.delete();
        #1;
        chk("rst_mid_lb_we", lb_we, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        start_line(51);
        wait_done();

        // Randomized lines with slot changes during the fill
        for (int it = 0; it < 40; it++) begin
            ny = $urandom_range(0, 479);
            for (int s = 0; s < NT; s++) begin
                tv[s] = ($urandom_range(0, 3) != 0) ? 1 : 0;
                tx[s] = ($urandom_range(0, 3) == 0) ? $urandom_range(600, 1023) : $urandom_range(0, 639);
                k = int'($urandom_range(0, 24)) - 4;
                ty[s] = ny - k;
                if (ty[s] < 0) ty[s] = 0;
                td[s] = $urandom_range(0, 3);
                ta[s] = $urandom_range(0, 1);
            end
            start_line(ny);
            for (int s = 0; s < NT; s++) begin
                tv[s] = $urandom_range(0, 1); tx[s] = $urandom_range(0, 1023);
                ty[s] = $urandom_range(0, 1023); td[s] = $urandom_range(0, 3);
                ta[s] = $urandom_range(0, 1);
            end
            repeat ($urandom_range(1, 6)) @(negedge clk);
            apply_tanks();
            wait_done();
        end

        chk("writes_pending", exp_addr.size(), 0);
        chk("overflow_pending", exp_ovf.size(), 0);
        chk("done_pending", exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
